approx_mul_ha_pipe: RTL

Parametrised, pipelined successor to the fixed 8x8 half-adder-array approximate multiplier. It pairs partial-product rows into half-adder arrays, with a per-transaction selectable approximation of low columns (OR sum, dropped carry). It then reduces the arrays and delivers the final product through valid/ready handshakes. It also flags each inexact result and keeps a saturating error-event counter for accuracy characterisation in the multiplier exploration flow.

---
 rtl/approx_mul_ha_pipe.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/approx_mul_ha_pipe.sv
// rtl/approx_mul_ha_pipe.sv - pipelined half-adder-array approximate multiplier with error tracking
module approx_mul_ha_pipe #(
  parameter int W           = 8,
  parameter int APPROX_COLS = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   p,
  output logic             out_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int NP = W / 2;
  localparam int PW = 2 * W;

  // Whole pipeline freezes while a result sits unaccepted at the output.
  logic stall;
  logic adv;
  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  // y padded so top bits live in relative columns 0..W-1 and bottom bits in 1..W.
  logic [W:0] y_top;
  logic [W:0] y_bot;
  assign y_top = {1'b0, y};
  assign y_bot = {y, 1'b0};

  logic [W:0]    ha_sum [NP];
  logic [W:0]    ha_car [NP];
  logic [NP-1:0] ha_err;

  // Per-pair half-adder arrays; low absolute columns optionally OR-summed with the carry dropped.
  always_comb begin
    logic t_bit;
    logic b_bit;
    logic ap;
    t_bit  = 1'b0;
    b_bit  = 1'b0;
    ap     = 1'b0;
    ha_err = '0;
    for (int k = 0; k < NP; k++) begin
      for (int j = 0; j <= W; j++) begin
        t_bit = x[2*k] & y_top[j];
        b_bit = x[2*k+1] & y_bot[j];
        ap    = approx_en && ((2*k + j) < APPROX_COLS);
        ha_sum[k][j] = ap ? (t_bit | b_bit) : (t_bit ^ b_bit);
        ha_car[k][j] = ~ap & t_bit & b_bit;
        ha_err[k]    = ha_err[k] | (ap & t_bit & b_bit);
      end
    end
  end

  logic          s1_v;
  logic [W:0]    s1_sum [NP];
  logic [W:0]    s1_car [NP];
  logic [NP-1:0] s1_err;

  // Stage 1 register: pair arrays and per-pair error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_err <= '0;
      for (int k = 0; k < NP; k++) begin
        s1_sum[k] <= '0;
        s1_car[k] <= '0;
      end
    end else if (adv) begin
      s1_v   <= in_valid;
      s1_err <= ha_err;
      for (int k = 0; k < NP; k++) begin
        s1_sum[k] <= ha_sum[k];
        s1_car[k] <= ha_car[k];
      end
    end
  end

  logic [PW-1:0] red_a;
  logic [PW-1:0] red_b;

  // Align each pair at column 2k; carries sit one column above their source column.
  always_comb begin
    red_a = '0;
    red_b = '0;
    for (int k = 0; k < NP; k++) begin
      red_a = red_a + (PW'(s1_sum[k]) << (2*k));
      red_b = red_b + (PW'(s1_car[k]) << (2*k + 1));
    end
  end

  logic          s2_v;
  logic [PW-1:0] s2_a;
  logic [PW-1:0] s2_b;
  logic          s2_err;

  // Stage 2 register: two reduced operands plus the combined error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v   <= 1'b0;
      s2_a   <= '0;
      s2_b   <= '0;
      s2_err <= 1'b0;
    end else if (adv) begin
      s2_v   <= s1_v;
      s2_a   <= red_a;
      s2_b   <= red_b;
      s2_err <= |s1_err;
    end
  end

  // Stage 3: final carry-propagate add into the output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      p         <= '0;
      out_err   <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_v;
      p         <= s2_a + s2_b;
      out_err   <= s2_err;
    end
  end

  // Saturating count of delivered inexact results; clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && out_err && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
